// File: rtl/gray_job_arbiter_if.sv
// gray_job_arbiter_if: job handshake bundle between two requesters and the gray counter arbiter
//   Req[1:0]       requester i wants a job
//   Steps0/Steps1  job length code N per requester (N+1 increments)
//   Gnt[1:0]       one-hot grant, 00 when idle
//   Busy, Done     job in progress / final-cycle pulse
//   GrayOut[2:0]   Gray code of the shared counter
//   Overflow       counter wrapped 7 -> 0
interface gray_job_arbiter_if;
  logic [1:0] Req;
  logic [2:0] Steps0;
  logic [2:0] Steps1;
  logic [1:0] Gnt;
  logic       Busy;
  logic       Done;
  logic [2:0] GrayOut;
  logic       Overflow;
  modport master (output Req, Steps0, Steps1, input Gnt, Busy, Done, GrayOut, Overflow);
  modport slave  (input Req, Steps0, Steps1, output Gnt, Busy, Done, GrayOut, Overflow);
endinterface

// File: rtl/gray_job_arbiter.sv
// gray_job_arbiter: round-robin job arbiter sequencing a shared 3-bit Gray-code counter
//   Clk    clock, rising edge
//   Reset  synchronous, active-high
//   bus    gray_job_arbiter_if.slave (Req/Steps0/Steps1 in; Gnt/Busy/Done/GrayOut/Overflow out)
//   Optional macro OVF_CLEAR_ON_GRANT_EN: clear Overflow on every grant edge.
module gray_job_arbiter (
  input  logic Clk,
  input  logic Reset,
  gray_job_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     state, state_nx;
  logic [2:0] cnt, remain;
  logic       last, pick, grant;
  logic [1:0] gnt, gnt_nx;
  logic       busy, busy_nx, done, done_nx, ovf, wrap;
  // Both requesting: serve the one not served last; otherwise the sole requester.
  assign pick  = (bus.Req == 2'b11) ? ~last : bus.Req[1];
  assign grant = (state == IDLE) && (|bus.Req);
  assign wrap  = (state == RUN) && (cnt == 3'd7);
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      remain <= '0;
      last   <= 1'b1;
      gnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      if (state == RUN) begin
        cnt <= cnt + 3'd1;
        if (remain != 3'd0) remain <= remain - 3'd1;
      end
      if (grant) begin
        remain <= pick ? bus.Steps1 : bus.Steps0;
        last   <= pick;
      end
`ifdef OVF_CLEAR_ON_GRANT_EN
      ovf <= grant ? 1'b0 : (ovf | wrap);
`else
      ovf <= ovf | wrap;
`endif
    end
  end
  always_comb begin
    state_nx = (state == IDLE) ? (grant ? RUN : IDLE) :
               (state == RUN)  ? ((remain == 3'd0) ? DONE : RUN) : IDLE;
  end
  always_comb begin
    gnt_nx  = (state_nx == IDLE) ? 2'b00 : (state == IDLE) ? (pick ? 2'b10 : 2'b01) : gnt;
    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == DONE);
  end
  assign bus.Gnt      = gnt;
  assign bus.Busy     = busy;
  assign bus.Done     = done;
  assign bus.Overflow = ovf;
  assign bus.GrayOut  = {cnt[2], cnt[2] ^ cnt[1], cnt[1] ^ cnt[0]};
endmodule

// File: tb/tb_gray_job_arbiter.sv
// tb_gray_job_arbiter: directed vector table plus a hand-written alternation sequence
module tb_gray_job_arbiter;
  logic Clk = 1'b0;
  logic Reset;
  int errors = 0;
  int checks = 0;
  always #5 Clk = ~Clk;
  gray_job_arbiter_if bus ();
  gray_job_arbiter dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [2:0] s0;
    logic [2:0] s1;
    logic [1:0] gnt;
    logic       busy;
    logic       done;
    logic [2:0] gray;
    logic       ovf;
  } vec_t;
  vec_t tbl[$];
`ifdef OVF_CLEAR_ON_GRANT_EN
  localparam logic OV = 1'b0;
`else
  localparam logic OV = 1'b1;
`endif
  task automatic v(input logic rst, input logic [1:0] req, input logic [2:0] s0, input logic [2:0] s1,
                   input logic [1:0] gnt, input logic busy, input logic done, input logic [2:0] gray,
                   input logic ovf);
    vec_t t;
    t.rst = rst; t.req = req; t.s0 = s0; t.s1 = s1;
    t.gnt = gnt; t.busy = busy; t.done = done; t.gray = gray; t.ovf = ovf;
    tbl.push_back(t);
  endtask
  task automatic step(input logic rst, input logic [1:0] req, input logic [2:0] s0, input logic [2:0] s1);
    @(negedge Clk);
    Reset = rst; bus.Req = req; bus.Steps0 = s0; bus.Steps1 = s1;
    @(posedge Clk);
    #1;
  endtask
  task automatic check(input string name, input int idx, input logic [1:0] gnt, input logic busy,
                       input logic done, input logic [2:0] gray, input logic ovf);
    checks++;
    if ({bus.Gnt, bus.Busy, bus.Done, bus.GrayOut, bus.Overflow} !== {gnt, busy, done, gray, ovf}) begin
      errors++;
      $display("FAIL %s[%0d]: got gnt=%b busy=%b done=%b gray=%b ovf=%b, want gnt=%b busy=%b done=%b gray=%b ovf=%b",
               name, idx, bus.Gnt, bus.Busy, bus.Done, bus.GrayOut, bus.Overflow, gnt, busy, done, gray, ovf);
    end
  endtask
  initial begin
    Reset = 1'b1; bus.Req = '0; bus.Steps0 = '0; bus.Steps1 = '0;
    // reset, then idle with no request
    v(1, 2'b00, 0, 0, 2'b00, 0, 0, 3'b000, 0);
    v(0, 2'b00, 0, 0, 2'b00, 0, 0, 3'b000, 0);
    // Steps0=3: grant, 4 increments, Done at edge 4, idle at edge 5
    v(0, 2'b01, 3, 0, 2'b01, 1, 0, 3'b000, 0);
    v(0, 2'b01, 3, 0, 2'b01, 1, 0, 3'b001, 0);
    v(0, 2'b01, 3, 0, 2'b01, 1, 0, 3'b011, 0);
    v(0, 2'b01, 3, 0, 2'b01, 1, 0, 3'b010, 0);
    v(0, 2'b01, 3, 0, 2'b01, 1, 1, 3'b110, 0);
    v(0, 2'b00, 3, 0, 2'b00, 0, 0, 3'b110, 0);
    // overflow scenario: reset, Steps0=5 brings cnt to 6
    v(1, 2'b00, 0, 0, 2'b00, 0, 0, 3'b000, 0);
    v(0, 2'b01, 5, 0, 2'b01, 1, 0, 3'b000, 0);
    v(0, 2'b00, 0, 0, 2'b01, 1, 0, 3'b001, 0);
    v(0, 2'b00, 0, 0, 2'b01, 1, 0, 3'b011, 0);
    v(0, 2'b00, 0, 0, 2'b01, 1, 0, 3'b010, 0);
    v(0, 2'b00, 0, 0, 2'b01, 1, 0, 3'b110, 0);
    v(0, 2'b00, 0, 0, 2'b01, 1, 0, 3'b111, 0);
    v(0, 2'b00, 0, 0, 2'b01, 1, 1, 3'b101, 0);
    v(0, 2'b00, 0, 0, 2'b00, 0, 0, 3'b101, 0);
    // requester 1, Steps1=2: 7, 0 (wrap), 1
    v(0, 2'b10, 0, 2, 2'b10, 1, 0, 3'b101, 0);
    v(0, 2'b00, 0, 2, 2'b10, 1, 0, 3'b100, 0);
    v(0, 2'b00, 0, 2, 2'b10, 1, 0, 3'b000, 1);
    v(0, 2'b00, 0, 2, 2'b10, 1, 1, 3'b001, 1);
    v(0, 2'b00, 0, 2, 2'b00, 0, 0, 3'b001, 1);
    // second job Steps0=0: Overflow sticky or cleared at grant
    v(0, 2'b01, 0, 0, 2'b01, 1, 0, 3'b001, OV);
    v(0, 2'b00, 0, 0, 2'b01, 1, 1, 3'b011, OV);
    v(0, 2'b00, 0, 0, 2'b00, 0, 0, 3'b011, OV);
    // Steps0=7 latched; Req dropped and Steps0 changed after grant
    v(0, 2'b01, 7, 0, 2'b01, 1, 0, 3'b011, OV);
    v(0, 2'b00, 1, 0, 2'b01, 1, 0, 3'b010, OV);
    v(0, 2'b00, 1, 0, 2'b01, 1, 0, 3'b110, OV);
    v(0, 2'b00, 1, 0, 2'b01, 1, 0, 3'b111, OV);
    v(0, 2'b00, 1, 0, 2'b01, 1, 0, 3'b101, OV);
    v(0, 2'b00, 1, 0, 2'b01, 1, 0, 3'b100, OV);
    v(0, 2'b00, 1, 0, 2'b01, 1, 0, 3'b000, 1);
    v(0, 2'b00, 1, 0, 2'b01, 1, 0, 3'b001, 1);
    v(0, 2'b00, 1, 0, 2'b01, 1, 1, 3'b011, 1);
    v(0, 2'b00, 1, 0, 2'b00, 0, 0, 3'b011, 1);
    // Steps0=5 aborted by Reset after 2 increments; no Done afterwards
    v(0, 2'b01, 5, 0, 2'b01, 1, 0, 3'b011, 1);
    v(0, 2'b00, 5, 0, 2'b01, 1, 0, 3'b010, 1);
    v(0, 2'b00, 5, 0, 2'b01, 1, 0, 3'b110, 1);
    v(1, 2'b00, 5, 0, 2'b00, 0, 0, 3'b000, 0);
    v(0, 2'b00, 5, 0, 2'b00, 0, 0, 3'b000, 0);
    v(0, 2'b00, 5, 0, 2'b00, 0, 0, 3'b000, 0);
    // Steps0=7 on a fresh counter: full wrap back to 0
    v(0, 2'b01, 7, 0, 2'b01, 1, 0, 3'b000, 0);
    v(0, 2'b00, 7, 0, 2'b01, 1, 0, 3'b001, 0);
    v(0, 2'b00, 7, 0, 2'b01, 1, 0, 3'b011, 0);
    v(0, 2'b00, 7, 0, 2'b01, 1, 0, 3'b010, 0);
    v(0, 2'b00, 7, 0, 2'b01, 1, 0, 3'b110, 0);
    v(0, 2'b00, 7, 0, 2'b01, 1, 0, 3'b111, 0);
    v(0, 2'b00, 7, 0, 2'b01, 1, 0, 3'b101, 0);
    v(0, 2'b00, 7, 0, 2'b01, 1, 0, 3'b100, 0);
    v(0, 2'b00, 7, 0, 2'b01, 1, 1, 3'b000, 1);
    v(0, 2'b00, 7, 0, 2'b00, 0, 0, 3'b000, 1);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].s0, tbl[i].s1);
      check("vec", i, tbl[i].gnt, tbl[i].busy, tbl[i].done, tbl[i].gray, tbl[i].ovf);
    end
    // Req=11 held with zero-length jobs: grants alternate 01/10, 3 cycles per job
    step(1, 2'b00, 0, 0);
    check("alt_reset", 0, 2'b00, 0, 0, 3'b000, 0);
    for (int k = 0; k < 12; k++) begin
      logic [2:0] g;
      logic [2:0] c;
      step(0, 2'b11, 0, 0);
      // counter has advanced once per completed RUN cycle (edge 3j+1)
      c = 3'((k + 2) / 3);
      g = {c[2], c[2] ^ c[1], c[1] ^ c[0]};
      check("alt", k, (k % 3 == 2) ? 2'b00 : (((k / 3) % 2 == 1) ? 2'b10 : 2'b01),
            (k % 3 != 2), (k % 3 == 1), g, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
